reg_alu_pipe: RTL

//   Parametrised register-file + ALU datapath with a 2-stage pipeline (EX, WB).

---
 rtl/reg_alu_pipe_if.sv | 27 ++
 rtl/reg_alu_pipe.sv | 93 +++++++++
 2 files changed

// File: rtl/reg_alu_pipe_if.sv
// reg_alu_pipe_if: instruction, operand and retire signals of the register-file/ALU pipeline
interface reg_alu_pipe_if #(parameter int WIDTH = 16, parameter int DEPTH = 8);
  localparam int ADDR_W = $clog2(DEPTH);
  logic in_valid;
  logic in_ready;
  logic sel;
  logic wr;
  logic [2:0] op;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out_a;
  logic [WIDTH-1:0] d_out_b;
  logic [WIDTH-1:0] result;
  logic out_valid;
  logic cout;
  logic zero;
  modport master(
    output in_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
    input in_ready, d_out_a, d_out_b, result, out_valid, cout, zero
  );
  modport slave(
    input in_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
    output in_ready, d_out_a, d_out_b, result, out_valid, cout, zero
  );
endinterface

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: regfile + 8-op ALU, EX/WB pipeline; REG_ALU_PIPE_BYPASS_EN forwards instead of stalling on RAW
module reg_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  reg_alu_pipe_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic ex_valid, ex_sel, ex_wr;
  logic [2:0] ex_op;
  logic [ADDR_W-1:0] ex_wr_addr;
  logic [WIDTH-1:0] ex_d_in, ex_a, ex_b;
  logic [WIDTH-1:0] alu, wb, op_a, op_b;
  logic alu_c;
  logic [WIDTH:0] add_s, sub_s;
  logic hit_a, hit_b, accept;
  logic [WIDTH-1:0] result;
  logic out_valid, cout, zero;
  assign add_s = {1'b0, ex_a} + {1'b0, ex_b};
  assign sub_s = {1'b0, ex_a} + {1'b0, ~ex_b} + {{WIDTH{1'b0}}, 1'b1};
  always_comb begin
    alu = '0;
    alu_c = 1'b0;
    case (ex_op)
      3'd0: {alu_c, alu} = add_s;
      3'd1: {alu_c, alu} = sub_s;
      3'd2: alu = ex_a & ex_b;
      3'd3: alu = ex_a | ex_b;
      3'd4: alu = ex_a ^ ex_b;
      3'd5: alu = ~ex_a;
      3'd6: {alu_c, alu} = {ex_a, 1'b0};
      default: alu = ex_b;
    endcase
  end
  assign wb = ex_sel ? alu : ex_d_in;
  assign hit_a = ex_valid & ex_wr & (ex_wr_addr == bus.rd_addr_a);
  assign hit_b = ex_valid & ex_wr & (ex_wr_addr == bus.rd_addr_b);
`ifdef REG_ALU_PIPE_BYPASS_EN
  assign op_a = hit_a ? wb : regs[bus.rd_addr_a];
  assign op_b = hit_b ? wb : regs[bus.rd_addr_b];
  assign bus.in_ready = ~reset;
`else
  // the regfile has no write-through, so a hazard waits one cycle for the retire
  assign op_a = regs[bus.rd_addr_a];
  assign op_b = regs[bus.rd_addr_b];
  assign bus.in_ready = ~reset & ~(hit_a | hit_b);
`endif
  assign accept = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      ex_valid <= 1'b0;
      ex_sel <= 1'b0;
      ex_wr <= 1'b0;
      ex_op <= '0;
      ex_wr_addr <= '0;
      ex_d_in <= '0;
      ex_a <= '0;
      ex_b <= '0;
      result <= '0;
      out_valid <= 1'b0;
      cout <= 1'b0;
      zero <= 1'b0;
    end else begin
      out_valid <= ex_valid;
      if (ex_valid) begin
        if (ex_wr) regs[ex_wr_addr] <= wb;
        result <= wb;
        cout <= alu_c;
        zero <= (alu == '0);
      end
      ex_valid <= accept;
      if (accept) begin
        ex_sel <= bus.sel;
        ex_wr <= bus.wr;
        ex_op <= bus.op;
        ex_wr_addr <= bus.wr_addr;
        ex_d_in <= bus.d_in;
        ex_a <= op_a;
        ex_b <= op_b;
      end
    end
  end
  assign bus.d_out_a = ex_a;
  assign bus.d_out_b = ex_b;
  assign bus.result = result;
  assign bus.out_valid = out_valid;
  assign bus.cout = cout;
  assign bus.zero = zero;
endmodule
